// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and bit-period helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Rounded clocks per bit; a zero baud rate yields 0 so the range check trips.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_freq);
    if (baud_freq == 0) return 0;
    return (clk_freq + baud_freq / 2) / baud_freq;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle o_tick every DIV clocks, realigned to zero on i_restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned p_clk_freq  = 50_000_000,
  parameter int unsigned p_baud_freq = 115_200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned DIV   = calc_div(p_clk_freq, p_baud_freq);
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: bit period below 2 clocks");
  end

  logic [CNT_W-1:0] cnt;

  // o_tick is registered one count early so it is high while cnt == DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      if (cnt == CNT_W'(DIV - 1)) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
      o_tick <= (cnt == CNT_W'(DIV - 2));
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, 5..9 data bits LSB first, optional parity, 1..2 stops.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned p_clk_freq  = 50_000_000,
  parameter int unsigned p_baud_freq = 115_200,
  parameter int unsigned p_data_bits = 8,
  parameter int unsigned p_parity    = 0,
  parameter int unsigned p_stop_bits = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [p_data_bits-1:0] i_data,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int unsigned DIV = calc_div(p_clk_freq, p_baud_freq);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: bit period below 2 clocks");
  end
  if (p_data_bits < 5 || p_data_bits > 9) begin : g_bad_data_bits
    $error("uart_tx_param: p_data_bits must be 5..9");
  end
  if (p_parity > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: p_parity must be 0, 1 or 2");
  end
  if (p_stop_bits < 1 || p_stop_bits > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: p_stop_bits must be 1 or 2");
  end

  uart_state_e            state;
  logic [p_data_bits-1:0] shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   parity_bit;
  logic                   tick;
  logic                   accept;

  assign accept = i_valid && o_ready && !i_rst;

  uart_baud_tick #(
    .p_clk_freq  (p_clk_freq),
    .p_baud_freq (p_baud_freq)
  ) u_baud (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (accept),
    .o_tick    (tick)
  );

  // Frame sequencer; o_tx is loaded with the next bit on the tick that ends the current one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      o_tx       <= 1'b1;
      o_ready    <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_START;
            shreg      <= i_data;
            parity_bit <= (^i_data) ^ (p_parity == PARITY_ODD);
            bit_cnt    <= '0;
            o_tx       <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_CNT_W'(p_data_bits - 1)) begin
              bit_cnt <= '0;
              if (p_parity != PARITY_NONE) begin
                state <= ST_PARITY;
                o_tx  <= parity_bit;
              end else begin
                state <= ST_STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            bit_cnt <= '0;
            o_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt == BIT_CNT_W'(p_stop_bits - 1)) begin
              state   <= ST_IDLE;
              bit_cnt <= '0;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            o_tx <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_tx    <= 1'b1;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter p_clk_freq, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter p_baud_freq, default 115_200, meaning line bit rate in baud.
REQ-003 SHALL have parameter p_data_bits, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter p_parity, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter p_stop_bits, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port i_valid  input  1  a data word is offered.
REQ-009 SHALL have port i_data  input  p_data_bits  the word to transmit.
REQ-010 SHALL have port o_ready  output  1  the block can accept a word this cycle.
REQ-011 SHALL have port o_tx  output  1  serial line, idle high.
REQ-012 SHALL have port o_busy  output  1  a frame is in progress.

Function
REQ-013 SHALL define bit period DIV = round(p_clk_freq / p_baud_freq) clocks; elaboration SHALL fail if DIV < 2 or any parameter is out of range.
REQ-014 SHALL accept a word on any cycle with i_valid and o_ready both high (handshake); i_data SHALL be registered on that cycle, and later changes to i_data SHALL NOT affect the frame.
REQ-015 SHALL keep o_ready high only in state IDLE, and low from the cycle after acceptance until return to IDLE.
REQ-016 SHALL run the FSM IDLE -> START -> DATA -> PARITY (only if p_parity != 0) -> STOP -> IDLE.
REQ-017 SHALL drive o_tx low starting on the cycle after acceptance; that cycle begins START.
REQ-018 SHALL hold each of START, each DATA bit, PARITY and each stop bit on o_tx for exactly DIV clocks.
REQ-019 SHALL send data LSB first; DATA SHALL advance after p_data_bits bit periods.
REQ-020 SHALL make the parity bit equal to the XOR of the data bits for even mode, and its inverse for odd mode.
REQ-021 SHALL drive o_tx high during STOP for p_stop_bits x DIV clocks, then enter IDLE.
REQ-022 SHALL make total frame length (1 + p_data_bits + (p_parity != 0) + p_stop_bits) x DIV clocks from the first low cycle.
REQ-023 SHALL raise o_ready on the first IDLE cycle after STOP; back-to-back words SHALL therefore produce one idle-high clock between frames.
REQ-024 SHALL restart the baud counter at zero on acceptance, so bit timing is phase-aligned to the handshake and not free-running.
REQ-025 SHALL drive o_busy high in every non-IDLE state, low in IDLE.
REQ-026 SHALL ignore i_valid while o_ready is low; no word is queued.

Reset
REQ-027 SHALL, when i_rst is high at a clock edge, enter IDLE with o_tx=1, o_ready=1, o_busy=0, baud counter=0, bit counter=0 and the data register cleared.
REQ-028 SHALL abort any frame in progress on reset; o_tx SHALL be high from the cycle after the reset edge.
REQ-029 SHALL ignore i_valid during any cycle in which i_rst is high.

Structure
REQ-030 SHALL take parity-mode constants (NONE/ODD/EVEN) and FSM state encoding from shared package uart_pkg, so the later receiver can reuse them.
REQ-031 SHALL place bit-period timing in sub-module uart_baud_tick (parameters p_clk_freq, p_baud_freq; inputs i_clk, i_rst, i_restart; output o_tick, a one-cycle pulse every DIV clocks). Dividing to a derived clock is forbidden; all logic stays on i_clk.

Verification (p_clk_freq=50_000_000, p_baud_freq=115_200, so DIV=434)
REQ-032 SHALL cover 8N1 with 0xA5: o_tx is 0, then 1,0,1,0,0,1,0,1, then 1, each for 434 clocks; total 4340 clocks; o_ready is high again 4341 clocks after acceptance.
REQ-033 SHALL cover 8E1 and 8O1 with 0xA5: the parity bit is 0 (even) and 1 (odd); frame is 4774 clocks.
REQ-034 SHALL cover p_data_bits=5, p_stop_bits=2 with 0x1F: data bits 1,1,1,1,1 follow the start bit, then 868 high clocks, then IDLE.
REQ-035 SHALL cover back-to-back: i_valid held high with 0x55 then 0xAA: two complete frames with exactly one idle-high clock between them; i_data changed mid-frame has no effect.
REQ-036 SHALL cover reset mid-frame: i_rst pulsed during DATA bit 3: next cycle o_tx=1, o_ready=1, o_busy=0; a new word of 0x3C then transmits correctly.
